// File: rtl/uart_tx_fifo_if.sv
// Write-side and line-side signals of uart_tx_fifo, plus a debug view of the transmitter state.
// master = byte producer (testbench or upstream datapath), slave = uart_tx_fifo.
interface uart_tx_fifo_if;
  // wr_en is a one-cycle strobe with no ready: a byte is taken when wr_en is high at a rising
  // edge and the FIFO has room (or frees a slot on that same edge); otherwise overflow pulses.
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       uartbusy;
  logic       uart_txd;
  logic [2:0] state;

  modport master (
    output wr_en, wr_data,
    input  full, empty, overflow, uartbusy, uart_txd, state
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, overflow, uartbusy, uart_txd, state
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter; uart_txd is registered and idles high.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 1_000_000,
  parameter int BAUD       = 9_600,
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  uart_tx_fifo_if.slave bus
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          txd_q, busy_q, ovf_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  logic bit_done, empty, pop, push, txd_d;

  assign bit_done = (baud_cnt == BAUD_LAST);
  assign empty    = (count == '0);
  // A full FIFO still accepts a write on the edge where the transmitter frees a slot.
  assign push     = bus.wr_en && ((count != DEPTH_C) || pop);

  // State register plus everything that advances with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= (state == S_IDLE || bit_done) ? '0 : baud_cnt + 1'b1;
      if (pop)
        bit_idx <= '0;
      else if (state == S_DATA && bit_done)
        bit_idx <= bit_idx + 1'b1;
      if (pop)
        shreg <= mem[rd_ptr];
      txd_q  <= txd_d;
      busy_q <= (state != S_IDLE) || !empty;
      ovf_q  <= bus.wr_en && !push;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.wr_data;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_START;
      S_START: if (bit_done) state_nxt = S_DATA;
      S_DATA:
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = S_PARITY;
`else
          state_nxt = S_STOP;
`endif
        end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_done) state_nxt = S_STOP;
`endif
      S_STOP:  if (bit_done) state_nxt = empty ? S_IDLE : S_START;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The head byte leaves the FIFO when a frame starts from idle or straight out of a stop bit.
  always_comb begin
    pop   = !empty && ((state == S_IDLE) || (state == S_STOP && bit_done));
    txd_d = 1'b1;
    case (state)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg[bit_idx];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = ^shreg;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  assign bus.full     = (count == DEPTH_C);
  assign bus.empty    = empty;
  assign bus.overflow = ovf_q;
  assign bus.uartbusy = busy_q;
  assign bus.uart_txd = txd_q;
  assign bus.state    = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DIV=10, depth 4): a serial monitor decodes frames and
// checks them against an expected-byte queue filled by the stimulus.
module tb_uart_tx_fifo;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CLK = NB * DIV;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [7:0] exp_q[$];
  int   start_q[$];
  logic last_par = 1'b0;

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .CLK_FREQ  (1_000_000),
    .BAUD      (100_000),
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock and cycle index: cyc equals the number of rising edges seen so far.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Drive one byte for the next rising edge; returns at the following negedge.
  task automatic push(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget, output int fall);
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.uartbusy) begin
        fall = cyc;
        break;
      end
    end
    check("idle_wait", {31'd0, bus.uartbusy}, 0);
  endtask

  // Monitor: samples each bit mid-period and scores the decoded byte.
  initial begin : monitor
    logic [NB-1:0] fr;
    logic [7:0]    exp;
    bit            abort;
    forever begin
      @(negedge clk);
      if (!reset && bus.uart_txd === 1'b0) begin
        start_q.push_back(cyc);
        abort = 0;
        fr    = '0;
        for (int t = 1; t <= (NB - 1) * DIV + DIV / 2; t++) begin
          @(negedge clk);
          if (reset) abort = 1;
          if (t % DIV == DIV / 2) fr[t / DIV] = bus.uart_txd;
        end
        if (!abort) begin
          check("start_bit", {31'd0, fr[0]}, 0);
          check("stop_bit", {31'd0, fr[NB-1]}, 1);
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_frame: got byte 0x%0h expected no frame (cyc %0d)", fr[8:1], cyc);
          end else begin
            exp = exp_q.pop_front();
            check("rx_byte", {24'd0, fr[8:1]}, {24'd0, exp});
`ifdef UART_TX_PARITY_EN
            check("parity_bit", {31'd0, fr[9]}, {31'd0, ^exp});
            last_par = fr[9];
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion (cyc %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k, fall, bad;
    reset       = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", {31'd0, bus.uart_txd}, 1);
    check("rst_busy", {31'd0, bus.uartbusy}, 0);
    check("rst_full", {31'd0, bus.full}, 0);
    check("rst_empty", {31'd0, bus.empty}, 1);
    check("rst_overflow", {31'd0, bus.overflow}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte: latency, busy timing, frame length.
    start_q.delete();
    exp_q.push_back(8'h55);
    push(8'h55);
    k = cyc;
    check("a_empty_at_write", {31'd0, bus.empty}, 0);
    check("a_busy_at_write", {31'd0, bus.uartbusy}, 0);
    @(negedge clk);
    check("a_busy_after_pop", {31'd0, bus.uartbusy}, 1);
    check("a_empty_after_pop", {31'd0, bus.empty}, 1);
    check("a_txd_before_start", {31'd0, bus.uart_txd}, 1);
    @(negedge clk);
    check("a_txd_start", {31'd0, bus.uart_txd}, 0);
    wait_idle(400, fall);
    check("a_busy_fall_cyc", fall, k + 2 + FRAME_CLK);
    check("a_start_cnt", start_q.size(), 1);
    if (start_q.size() >= 1) check("a_start_cyc", start_q[0], k + 2);
    repeat (5) @(negedge clk);

    // Back-to-back frames with no idle gap.
    start_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    push(8'hA5);
    k = cyc;
    push(8'h3C);
    wait_to(k + FRAME_CLK);
    check("b_empty_before_pop2", {31'd0, bus.empty}, 0);
    @(negedge clk);
    check("b_empty_at_pop2", {31'd0, bus.empty}, 1);
    wait_idle(400, fall);
    check("b_start_cnt", start_q.size(), 2);
    if (start_q.size() >= 2) begin
      check("b_start0_cyc", start_q[0], k + 2);
      check("b_gap", start_q[1] - start_q[0], FRAME_CLK);
    end
    repeat (5) @(negedge clk);

    // Overflow, then a write into a full FIFO on the pop edge.
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i * 8'h11));
    push(8'h11);
    k = cyc;
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    check("c_full", {31'd0, bus.full}, 1);
    check("c_no_ovf_yet", {31'd0, bus.overflow}, 0);
    push(8'h66);
    check("c_ovf_pulse", {31'd0, bus.overflow}, 1);
    check("c_full_kept", {31'd0, bus.full}, 1);
    @(negedge clk);
    check("c_ovf_cleared", {31'd0, bus.overflow}, 0);
    wait_to(k + FRAME_CLK);
    check("d_full_before", {31'd0, bus.full}, 1);
    exp_q.push_back(8'h77);
    push(8'h77);
    check("d_full_after", {31'd0, bus.full}, 1);
    check("d_no_ovf", {31'd0, bus.overflow}, 0);
    wait_idle(1000, fall);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 of 0x96 (bit 3 = 0) with a second byte queued.
    push(8'h96);
    k = cyc;
    push(8'h69);
    wait_to(k + 45);
    check("e_txd_bit3", {31'd0, bus.uart_txd}, 0);
    reset = 1'b1;
    #1;
    check("e_txd_reset", {31'd0, bus.uart_txd}, 1);
    check("e_busy_reset", {31'd0, bus.uartbusy}, 0);
    check("e_empty_reset", {31'd0, bus.empty}, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.uart_txd !== 1'b1 || bus.uartbusy !== 1'b0) bad++;
    end
    check("e_idle_after_reset", bad, 0);

    // Recovery after reset.
    exp_q.push_back(8'hC3);
    push(8'hC3);
    wait_idle(400, fall);

`ifdef UART_TX_PARITY_EN
    exp_q.push_back(8'h07);
    push(8'h07);
    wait_idle(400, fall);
    check("p_parity_07", {31'd0, last_par}, 1);
    exp_q.push_back(8'h03);
    push(8'h03);
    wait_idle(400, fall);
    check("p_parity_03", {31'd0, last_par}, 0);
`endif

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    check("all_frames_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
